// File: rtl/serial_deser_if.sv
// Bit-stream handshake bundle between the upstream DFF stage (master) and serial_deser (slave).
// Carries the serial input controls and the registered word/status outputs.
interface serial_deser_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             en;
    logic             d;
    logic             clear;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             busy;
    logic [CW-1:0]    count;
    logic             perr;

    modport master (
        output en, d, clear,
        input  q, valid, busy, count, perr
    );

    modport slave (
        input  en, d, clear,
        output q, valid, busy, count, perr
    );
endinterface

// File: rtl/serial_deser.sv
// MSB-first serial-to-parallel deserializer with a one-cycle valid strobe per completed word.
// Optional even-parity bit after each word when SERIAL_DESER_PARITY_EN is defined.
module serial_deser #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_deser_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SERIAL_DESER_PARITY_EN
    // Full word is kept so it can be checked and loaded on the parity edge.
    localparam int unsigned SRW = WIDTH;
    typedef enum logic [1:0] {StIdle, StShift, StPar} state_t;
`else
    localparam int unsigned SRW = WIDTH - 1;
    typedef enum logic [1:0] {StIdle, StShift} state_t;
`endif

    state_t           r_state;
    logic [SRW-1:0]   r_sr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             r_busy;
    logic [WIDTH-1:0] w_word;
    logic             w_last;

    assign w_word = {r_sr[WIDTH-2:0], bus.d};
    assign w_last = (r_count == CW'(WIDTH - 1));

`ifdef SERIAL_DESER_PARITY_EN
    logic r_perr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_sr    <= '0;
            r_count <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (bus.clear) begin
                // Abort wins over en, even on the completing bit; q is left untouched.
                r_state <= StIdle;
                r_sr    <= '0;
                r_count <= '0;
                r_busy  <= 1'b0;
            end else if (bus.en) begin
                unique case (r_state)
                    StIdle: begin
                        r_sr    <= w_word[SRW-1:0];
                        r_count <= CW'(1);
                        r_state <= StShift;
                        r_busy  <= 1'b1;
                    end
                    StShift: begin
                        r_sr <= w_word[SRW-1:0];
                        if (w_last) begin
`ifdef SERIAL_DESER_PARITY_EN
                            r_count <= r_count + CW'(1);
                            r_state <= StPar;
`else
                            r_q     <= w_word;
                            r_valid <= 1'b1;
                            r_count <= '0;
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
`ifdef SERIAL_DESER_PARITY_EN
                    StPar: begin
                        r_q     <= r_sr;
                        r_valid <= 1'b1;
                        r_perr  <= (^r_sr) ^ bus.d;
                        r_count <= '0;
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
`endif
                    default: begin
                        r_state <= StIdle;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.q     = r_q;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
    assign bus.count = r_count;
`ifdef SERIAL_DESER_PARITY_EN
    assign bus.perr  = r_perr;
`else
    assign bus.perr  = 1'b0;
`endif
endmodule

// File: doc/serial_deser.md
# serial_deser

Serial-to-parallel deserializer that collects the single-bit `q` stream produced by the `dff` sampling stage into `WIDTH`-bit words. It sits directly downstream of the flip-flop stage. It shifts one bit per enabled clock, MSB first, and presents each completed word with a one-cycle `valid` strobe. It is the first multi-bit sequential stage in the COA datapath exercises.

## Interface
- `WIDTH`, 8: bits per word; legal range 2–32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  `d` carries a valid bit this cycle.
- `d`  input  1  serial data bit, driven by the upstream DFF `q`.
- `clear`  input  1  synchronous abort; discards the partial word.
- `q`  output  WIDTH  last completed word.
- `valid`  output  1  one-cycle strobe: `q` was updated at the previous edge.
- `busy`  output  1  partial word in progress.
- `count`  output  $clog2(WIDTH+1)  number of data bits collected so far.
- `perr`  output  1  parity error flag; qualified by `valid`.

## Operation
- FSM states: IDLE, SHIFT, PAR (PAR exists only with the macro).
- IDLE → SHIFT on `en`=1. That first bit is shifted in and `count` becomes 1.
- SHIFT:
  - Each `en`=1 edge does `sr <= {sr[WIDTH-2:0], d}` and increments `count`.
  - `en`=0 holds all state.
- The edge that takes the WIDTH-th bit:
  - without the macro: `q <= {sr[WIDTH-2:0], d}`, `valid <= 1`, `count <= 0`, state → IDLE.
  - with the macro: state → PAR and `count` stays at WIDTH.
- `valid` is high for exactly one cycle and then deasserts, regardless of `en`.
- `q` holds its value until the next word completes.
- `busy` is 1 in SHIFT and PAR, and 0 in IDLE.
- `clear`=1 at an edge: state → IDLE, `count` → 0, partial shift register is discarded, `valid` → 0.
  - `q` is unchanged.
  - `clear` has priority over `en`, including on the completing bit; that word is lost and no `valid` is produced.
- Back-to-back words need no gap. A bit arriving in the cycle `valid` is high starts the next word.
- Reset values (immediate on `rst_n` low, independent of `clk`): `q`=0, `valid`=0, `busy`=0, `count`=0, `perr`=0, state IDLE.
- Reset mid-word discards the partial word. The first bit after `rst_n` rises is bit MSB of a new word.

## Timing
- Latency is one edge: the last data bit (or the parity bit, with the macro) is sampled at edge N, and `q`/`valid` are visible after edge N.
- All outputs are registered. There is no combinational path from `d`, `en` or `clear` to any output.
- Throughput:
  - without the macro: one word per WIDTH enabled cycles.
  - with the macro: one word per WIDTH+1 enabled cycles.
- `rst_n` deassertion is assumed synchronous to `clk` by the upstream reset synchronizer.

## Configuration
- `SERIAL_DESER_PARITY_EN` defined:
  - After the WIDTH data bits, one more `en`=1 bit is taken in state PAR.
  - That edge loads `q`, pulses `valid`, and sets `perr` = (^data) ^ d. Parity is even, so `perr`=1 means a mismatch.
  - `perr` holds its value until the next `valid`.
  - `clear` in PAR discards the word.
- Not defined: the PAR state is not generated and `perr` is tied 0.

## Test plan
- Reset, then `en`=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 → after the 8th edge `q`=8'hA5, `valid` high one cycle, `count`=0, `busy`=0.
- Same word with `en`=0 gaps of 3 cycles after bits 2 and 5 → `q`=8'hA5 once; no `valid` during the gaps; `count` holds during the gaps.
- Words 8'h3C then 8'hC3 streamed with no gap → `valid` pulses twice, 8 cycles apart; `q`=8'h3C, then 8'hC3.
- 5 bits shifted, then `clear` together with `en`=1, then 8'hFF → `q` stays 8'h00 until the 8'hFF word completes, then `q`=8'hFF; exactly one `valid`.
- `rst_n` pulled low mid-clock after 4 bits → all outputs 0 immediately; next 8'h81 decodes correctly.
- With `SERIAL_DESER_PARITY_EN`:
  - 8'h07 followed by parity bit 1 → `valid` with `perr`=0.
  - 8'h07 followed by parity bit 0 → `valid` with `perr`=1.
